// File: rtl/universal_shift_register.sv
`default_nettype none
// ============================================================================
// Module      : universal_shift_register
// Description : Parallel-load register with shifts/rotates in both directions,
//               executed one bit per cycle behind a valid/ready command port.
// Revision    : 1.0 - initial release
// ============================================================================
module universal_shift_register #(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [CW-1:0]    cmd_amt,
    input  logic [WIDTH-1:0] load_data,
    input  logic             sin_l,
    input  logic             sin_r,
    output logic [WIDTH-1:0] q,
    output logic             sout_l,
    output logic             sout_r,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0]    c_op_nop  = 3'b000;
    localparam logic [2:0]    c_op_load = 3'b001;
    localparam logic [2:0]    c_op_shl  = 3'b010;
    localparam logic [2:0]    c_op_shr  = 3'b011;
    localparam logic [2:0]    c_op_rol  = 3'b100;
    localparam logic [2:0]    c_op_ror  = 3'b101;
    localparam logic [2:0]    c_op_asr  = 3'b110;
    localparam logic [2:0]    c_op_clr  = 3'b111;
    localparam logic [CW-1:0] c_width   = CW'(WIDTH);
    localparam logic [CW-1:0] c_one     = CW'(1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic             done_q, done_d;

    // Single-bit step applied to the live register value every burst cycle.
    function automatic logic [WIDTH-1:0] shift_one(
        input logic [WIDTH-1:0] v,
        input logic [2:0]       op,
        input logic             sl,
        input logic             sr
    );
        logic [WIDTH-1:0] r;
        r = v;
        case (op)
            c_op_shl: r = {v[WIDTH-2:0], sr};
            c_op_shr: r = {sl, v[WIDTH-1:1]};
            c_op_rol: r = {v[WIDTH-2:0], v[WIDTH-1]};
            c_op_ror: r = {v[0], v[WIDTH-1:1]};
            c_op_asr: r = {v[WIDTH-1], v[WIDTH-1:1]};
            default:  r = v;
        endcase
        return r;
    endfunction

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        c_op_nop: done_d = 1'b1;
                        c_op_load: begin
                            q_d    = load_data;
                            done_d = 1'b1;
                        end
                        c_op_clr: begin
                            q_d    = '0;
                            done_d = 1'b1;
                        end
                        default: begin
                            // Zero-length shift completes like a NOP.
                            if (cmd_amt == '0) begin
                                done_d = 1'b1;
                            end else begin
                                op_d    = cmd_op;
                                cnt_d   = (cmd_amt > c_width) ? c_width : cmd_amt;
                                state_d = SHIFT;
                            end
                        end
                    endcase
                end
            end
            SHIFT: begin
                q_d   = shift_one(q_q, op_q, sin_l, sin_r);
                cnt_d = cnt_q - c_one;
                if (cnt_q == c_one) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            q_q     <= '0;
            cnt_q   <= '0;
            op_q    <= c_op_nop;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            done_q  <= done_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q == SHIFT);
    assign done      = done_q;
    assign q         = q_q;
    assign sout_l    = q_q[WIDTH-1];
    assign sout_r    = q_q[0];

endmodule
`default_nettype wire

// File: tb/tb_universal_shift_register.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_universal_shift_register
// Description : Scoreboard bench for universal_shift_register (WIDTH=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_universal_shift_register;

    localparam int WIDTH = 8;
    localparam int CW    = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [2:0]       cmd_op = 3'd0;
    logic [CW-1:0]    cmd_amt = '0;
    logic [WIDTH-1:0] load_data = '0;
    logic             sin_l = 1'b0;
    logic             sin_r = 1'b0;
    logic [WIDTH-1:0] q;
    logic             sout_l;
    logic             sout_r;
    logic             busy;
    logic             done;

    universal_shift_register #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_amt   (cmd_amt),
        .load_data (load_data),
        .sin_l     (sin_l),
        .sin_r     (sin_r),
        .q         (q),
        .sout_l    (sout_l),
        .sout_r    (sout_r),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] q;
        int         n;
    } exp_t;

    exp_t       exp_q[$];
    int         acc_q[$];
    logic [7:0] model_q = 8'h00;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         busy_cnt = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Whole-command result from plain integer arithmetic; n = busy cycles.
    function automatic logic [7:0] model(input logic [7:0] v, input logic [2:0] op,
                                         input int amt, input logic [7:0] d,
                                         input logic sl, input logic sr, output int n);
        int x, m, ones, s;
        x = v;
        n = 0;
        case (op)
            3'd0: return v;
            3'd1: return d;
            3'd7: return 8'h00;
            default: ;
        endcase
        n = (amt > 8) ? 8 : amt;
        if (n == 0) return v;
        ones = (1 << n) - 1;
        m    = n % 8;
        case (op)
            3'd2: return 8'(((x << n) | (sr ? ones : 0)) & 255);
            3'd3: return 8'((x >> n) | (sl ? ((ones << (8 - n)) & 255) : 0));
            3'd4: return 8'(((x << m) | (x >> ((8 - m) % 8))) & 255);
            3'd5: return 8'(((x >> m) | (x << ((8 - m) % 8))) & 255);
            default: begin
                s = (x >= 128) ? x - 256 : x;
                return 8'((s >>> n) & 255);
            end
        endcase
    endfunction

    // Command fields are presented at once (held while busy); serial inputs
    // change only once the block is idle so an ongoing burst is undisturbed.
    task automatic issue(input logic [2:0] op, input logic [3:0] amt, input logic [7:0] d,
                         input logic sl, input logic sr);
        int         n;
        logic [7:0] nq;
        bit         ok;
        ok        = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_amt   = amt;
        load_data = d;
        for (int i = 0; i < 60; i++) begin
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #2;
        end
        if (!ok) begin
            chk("issue_ready_timeout", 0, 1);
            cmd_valid = 1'b0;
            return;
        end
        sin_l = sl;
        sin_r = sr;
        nq    = model(model_q, op, int'(amt), d, sl, sr, n);
        exp_q.push_back('{nq, n});
        model_q = nq;
        @(posedge clk); #2;
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #2;
        end
        if (!ok) chk("drain_timeout", exp_q.size(), 0);
    endtask

    // Monitor: every done pulse retires one expected command.
    always @(negedge clk) begin
        exp_t e;
        int   a;
        cyc++;
        if (!rst) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                if (exp_q.size() == 0 || acc_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    a = acc_q.pop_front();
                    chk("q_at_done", int'(q), int'(e.q));
                    chk("busy_cycles", busy_cnt, e.n);
                    chk("done_latency", cyc - a, e.n + 1);
                    chk("sout_l", int'(sout_l), int'(e.q[7]));
                    chk("sout_r", int'(sout_r), int'(e.q[0]));
                    chk("ready_in_done", int'(cmd_ready), 1);
                end
                busy_cnt = 0;
            end
            if (cmd_valid && cmd_ready) acc_q.push_back(cyc);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] t1 [3];
        t1[0] = 8'h4B;
        t1[1] = 8'h97;
        t1[2] = 8'h2F;

        repeat (3) @(posedge clk);
        #2;
        chk("reset_q", int'(q), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_ready", int'(cmd_ready), 1);
        rst = 1'b1;
        @(posedge clk); #2;

        issue(3'd1, 4'd0, 8'hA5, 1'b0, 1'b0);
        issue(3'd2, 4'd3, 8'h00, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #2;
            chk("shl_step_q", int'(q), int'(t1[k]));
            chk("shl_step_sout_l", int'(sout_l), int'(t1[k][7]));
        end
        drain();
        chk("t1_shl_final", int'(q), 8'h2F);

        issue(3'd1, 4'd0, 8'hA5, 1'b0, 1'b0);
        issue(3'd5, 4'd4, 8'h00, 1'b0, 1'b0);
        drain();
        chk("t2_ror4", int'(q), 8'h5A);
        issue(3'd1, 4'd0, 8'hA5, 1'b0, 1'b0);
        issue(3'd4, 4'd8, 8'h00, 1'b1, 1'b1);
        drain();
        chk("t2_rol8", int'(q), 8'hA5);

        issue(3'd1, 4'd0, 8'h90, 1'b0, 1'b0);
        issue(3'd6, 4'd2, 8'h00, 1'b0, 1'b0);
        drain();
        chk("t3_asr2", int'(q), 8'hE4);
        issue(3'd1, 4'd0, 8'h90, 1'b0, 1'b0);
        issue(3'd3, 4'd2, 8'h00, 1'b0, 1'b1);
        drain();
        chk("t3_shr2", int'(q), 8'h24);

        issue(3'd2, 4'd0, 8'h00, 1'b1, 1'b1);
        drain();
        chk("t4_shl0", int'(q), 8'h24);
        issue(3'd2, 4'd15, 8'h00, 1'b1, 1'b0);
        drain();
        chk("t4_shl15", int'(q), 8'h00);

        issue(3'd1, 4'd0, 8'h3A, 1'b0, 1'b0);
        issue(3'd2, 4'd5, 8'h00, 1'b0, 1'b1);
        issue(3'd1, 4'd0, 8'hFF, 1'b0, 1'b0);
        drain();
        chk("t5_held_load", int'(q), 8'hFF);

        issue(3'd2, 4'd8, 8'h00, 1'b0, 1'b0);
        @(posedge clk); #2;
        #1 rst = 1'b0;
        #1;
        chk("t6_rst_q", int'(q), 0);
        chk("t6_rst_busy", int'(busy), 0);
        chk("t6_rst_done", int'(done), 0);
        exp_q.delete();
        acc_q.delete();
        model_q = 8'h00;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        chk("t6_no_done_after_abort", int'(busy), 0);
        issue(3'd1, 4'd0, 8'h3C, 1'b0, 1'b0);
        drain();
        chk("t6_load_after_reset", int'(q), 8'h3C);

        for (int i = 0; i < 150; i++) begin
            issue(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 8'($urandom),
                  1'($urandom), 1'($urandom));
        end
        drain();
        chk("random_final_q", int'(q), int'(model_q));
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
